// File: rtl/layer_compositor.sv
// layer_compositor: per-pixel layer priority select with colour key, frame-latched mask and overlay fade
module layer_compositor #(
  parameter int N_LAYERS = 4,
  parameter logic [11:0] KEY_COLOR = 12'hF0F,
  parameter bit FADE_EN = 1'b1,
  parameter int FADE_FRAMES = 2,
  parameter int IDX_W = $clog2(N_LAYERS + 2)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    pix_valid,
  input  logic                    video_off,
  input  logic                    frame_start,
  input  logic [N_LAYERS-1:0]     layer_on,
  input  logic [12*N_LAYERS-1:0]  layer_rgb,
  input  logic [N_LAYERS-1:0]     layer_mask,
  input  logic [11:0]             bg_rgb,
  input  logic                    overlay_sel,
  input  logic [11:0]             overlay_rgb,
  output logic [11:0]             rgb_out,
  output logic                    rgb_valid,
  output logic [IDX_W-1:0]        win_idx,
  output logic                    fade_busy
);
  localparam int CW = FADE_FRAMES > 1 ? $clog2(FADE_FRAMES) : 1;
  typedef enum logic [1:0] {IDLE, FADE_OUT, FADE_IN} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [4:0] level;
  logic [N_LAYERS-1:0] mask_sh;
  logic ovl_sh, s1_v, wrap;
  logic [11:0] s1_rgb, sel_rgb;
  logic [IDX_W-1:0] s1_idx, sel_idx;
  assign wrap = cnt == CW'(FADE_FRAMES - 1);
  function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] l);
    logic [8:0] p;
    p = 9'(c) * 9'(l);
    return 4'(p >> 4);
  endfunction
  // descending scan so the lowest qualifying layer wins
  always_comb begin
    sel_rgb = bg_rgb;
    sel_idx = IDX_W'(N_LAYERS);
    for (int i = N_LAYERS - 1; i >= 0; i--)
      if (layer_on[i] && mask_sh[i] && layer_rgb[12*i +: 12] != KEY_COLOR) begin
        sel_rgb = layer_rgb[12*i +: 12];
        sel_idx = IDX_W'(i);
      end
    if (ovl_sh) begin
      sel_rgb = overlay_rgb;
      sel_idx = IDX_W'(N_LAYERS + 1);
    end
    if (video_off) begin
      sel_rgb = 12'h000;
      sel_idx = IDX_W'(N_LAYERS);
    end
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      s1_v <= 1'b0;
      s1_rgb <= 12'h000;
      s1_idx <= IDX_W'(N_LAYERS);
      rgb_valid <= 1'b0;
      rgb_out <= 12'h000;
      win_idx <= IDX_W'(N_LAYERS);
    end else begin
      s1_v <= pix_valid;
      if (pix_valid) begin
        s1_rgb <= sel_rgb;
        s1_idx <= sel_idx;
      end
      rgb_valid <= s1_v;
      if (s1_v) begin
        rgb_out <= {scale(s1_rgb[11:8], level), scale(s1_rgb[7:4], level), scale(s1_rgb[3:0], level)};
        win_idx <= s1_idx;
      end
    end
  // the overlay only switches while the screen is black (level 0)
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      cnt <= '0;
      level <= 5'd16;
      mask_sh <= '0;
      ovl_sh <= 1'b0;
      fade_busy <= 1'b0;
    end else if (frame_start) begin
      mask_sh <= layer_mask;
      case (state)
        IDLE:
          if (overlay_sel != ovl_sh) begin
            if (FADE_EN) begin
              cnt <= '0;
              state <= FADE_OUT;
              fade_busy <= 1'b1;
            end else ovl_sh <= overlay_sel;
          end
        FADE_OUT:
          if (level == 5'd0) begin
            ovl_sh <= overlay_sel;
            cnt <= '0;
            state <= FADE_IN;
          end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap) level <= level - 5'd1;
          end
        FADE_IN: begin
          cnt <= wrap ? '0 : cnt + 1'b1;
          if (wrap) begin
            level <= level + 5'd1;
            if (level == 5'd15) begin
              state <= IDLE;
              fade_busy <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_layer_compositor.sv
// tb_layer_compositor: directed checks of priority, key, mask timing, fade and reset
module tb_layer_compositor;
  logic clk, rstn, pix_valid, video_off, frame_start, overlay_sel;
  logic [3:0] layer_on, layer_mask;
  logic [11:0] rgb [4];
  logic [47:0] layer_rgb;
  logic [11:0] bg_rgb, overlay_rgb, rgb_out, rgb_out0;
  logic rgb_valid, rgb_valid0, fade_busy, fade_busy0;
  logic [2:0] win_idx, win_idx0;
  int checks = 0, errors = 0;
  logic [11:0] gv [3] = '{12'h1A2, 12'h3B4, 12'hC5D};
  assign layer_rgb = {rgb[3], rgb[2], rgb[1], rgb[0]};

  layer_compositor #(.FADE_EN(1'b1), .FADE_FRAMES(1)) dut (
    .clk(clk), .rstn(rstn), .pix_valid(pix_valid), .video_off(video_off),
    .frame_start(frame_start), .layer_on(layer_on), .layer_rgb(layer_rgb),
    .layer_mask(layer_mask), .bg_rgb(bg_rgb), .overlay_sel(overlay_sel),
    .overlay_rgb(overlay_rgb), .rgb_out(rgb_out), .rgb_valid(rgb_valid),
    .win_idx(win_idx), .fade_busy(fade_busy));

  layer_compositor #(.FADE_EN(1'b0), .FADE_FRAMES(1)) dut0 (
    .clk(clk), .rstn(rstn), .pix_valid(pix_valid), .video_off(video_off),
    .frame_start(frame_start), .layer_on(layer_on), .layer_rgb(layer_rgb),
    .layer_mask(layer_mask), .bg_rgb(bg_rgb), .overlay_sel(overlay_sel),
    .overlay_rgb(overlay_rgb), .rgb_out(rgb_out0), .rgb_valid(rgb_valid0),
    .win_idx(win_idx0), .fade_busy(fade_busy0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic pix(input string tag, input logic [11:0] er, input logic [2:0] ei, input bit fs);
    @(negedge clk);
    pix_valid = 1'b1;
    frame_start = fs;
    @(negedge clk);
    pix_valid = 1'b0;
    frame_start = 1'b0;
    check({tag, "_lat"}, 16'(rgb_valid), 16'd0);
    @(negedge clk);
    check({tag, "_v"}, 16'(rgb_valid), 16'd1);
    check({tag, "_rgb"}, 16'(rgb_out), 16'(er));
    check({tag, "_idx"}, 16'(win_idx), 16'(ei));
    @(negedge clk);
    check({tag, "_pulse"}, 16'(rgb_valid), 16'd0);
    check({tag, "_hold"}, 16'(rgb_out), 16'(er));
  endtask

  initial begin
    rstn = 1'b1; pix_valid = 1'b0; video_off = 1'b0; frame_start = 1'b0;
    layer_on = 4'h0; layer_mask = 4'h0; bg_rgb = 12'h456;
    overlay_sel = 1'b0; overlay_rgb = 12'h5A5;
    rgb = '{12'h123, 12'h0F0, 12'hF00, 12'hABC};
    #1 rstn = 1'b0;
    #2;
    check("rst_rgb", 16'(rgb_out), 16'h000);
    check("rst_valid", 16'(rgb_valid), 16'd0);
    check("rst_idx", 16'(win_idx), 16'd4);
    check("rst_busy", 16'(fade_busy), 16'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    layer_mask = 4'hF;
    frame();
    layer_on = 4'b0110;
    pix("prio", 12'h0F0, 3'd1, 1'b0);
    rgb[1] = 12'hF0F;
    pix("key1", 12'hF00, 3'd2, 1'b0);
    rgb[2] = 12'hF0F;
    pix("keyall", 12'h456, 3'd4, 1'b0);
    rgb[1] = 12'h0F0;
    rgb[2] = 12'hF00;
    layer_mask = 4'b1101;
    pix("mask_old", 12'h0F0, 3'd1, 1'b0);
    pix("mask_fs", 12'h0F0, 3'd1, 1'b1);
    pix("mask_new", 12'hF00, 3'd2, 1'b0);
    video_off = 1'b1;
    pix("voff", 12'h000, 3'd4, 1'b0);
    video_off = 1'b0;
    layer_on = 4'h0;
    @(negedge clk);
    pix_valid = 1'b1; bg_rgb = 12'h111;
    @(negedge clk);
    bg_rgb = 12'h222;
    @(negedge clk);
    pix_valid = 1'b0;
    check("b2b_v0", 16'(rgb_valid), 16'd1);
    check("b2b_rgb0", 16'(rgb_out), 16'h111);
    @(negedge clk);
    check("b2b_v1", 16'(rgb_valid), 16'd1);
    check("b2b_rgb1", 16'(rgb_out), 16'h222);
    for (int k = 0; k < 3; k++) begin
      bg_rgb = gv[k];
      pix("gap", gv[k], 3'd4, 1'b0);
    end
    bg_rgb = 12'hFFF;
    overlay_sel = 1'b1;
    pix("pre_fs", 12'hFFF, 3'd4, 1'b0);
    check("d0_pre_idx", 16'(win_idx0), 16'd4);
    frame();
    check("busy_rise", 16'(fade_busy), 16'd1);
    check("d0_busy", 16'(fade_busy0), 16'd0);
    pix("lvl16", 12'hFFF, 3'd4, 1'b0);
    check("d0_ovl_rgb", 16'(rgb_out0), 16'h5A5);
    check("d0_ovl_idx", 16'(win_idx0), 16'd5);
    for (int p = 1; p <= 11; p++) begin
      frame();
      if (p == 8) pix("lvl8", 12'h777, 3'd4, 1'b0);
    end
    pix("lvl5", 12'h444, 3'd4, 1'b0);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("arst_rgb", 16'(rgb_out), 16'h000);
    check("arst_idx", 16'(win_idx), 16'd4);
    check("arst_busy", 16'(fade_busy), 16'd0);
    @(negedge clk);
    rstn = 1'b1;
    pix("rst_lvl", 12'hFFF, 3'd4, 1'b0);
    frame();
    check("busy_rise2", 16'(fade_busy), 16'd1);
    for (int p = 1; p <= 33; p++) begin
      frame();
      if (p == 8) pix("f_lvl8", 12'h777, 3'd4, 1'b0);
      if (p == 16) pix("f_lvl0", 12'h000, 3'd4, 1'b0);
      if (p == 17) pix("f_latch", 12'h000, 3'd5, 1'b0);
      if (p == 25) pix("f_in8", 12'h252, 3'd5, 1'b0);
      if (p == 32) check("busy_hold", 16'(fade_busy), 16'd1);
      if (p == 33) check("busy_fall", 16'(fade_busy), 16'd0);
    end
    pix("f_done", 12'h5A5, 3'd5, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/layer_compositor.md
# layer_compositor

Parametrised pixel compositor that replaces the hard-wired sprite priority mux in the top level. It selects the highest-priority visible layer per pixel from N sprite layers, a background and a full-screen overlay (cover, success and game-over screens). Selection uses a per-layer frame-latched enable mask and a transparent colour key. A frame-synchronous fade FSM blacks the screen out and back in on overlay changes. The block sits between the sprite and background units and `vgac`, running on the system clock and qualified by a pixel-enable strobe.

## Interface

Parameters:
- `N_LAYERS`, default 4: number of sprite layers. Legal range 1–8.
- `KEY_COLOR`, default 12'hF0F: layer pixel value treated as transparent.
- `FADE_EN`, default 1: when 0, overlay changes apply at the next `frame_start` with no fade.
- `FADE_FRAMES`, default 2: frames per brightness step. Minimum 1.
- `IDX_W`, derived as `$clog2(N_LAYERS+2)`: width of `win_idx`.

Ports:
- `clk`, in, 1: system clock.
- `rstn`, in, 1: reset, asynchronous, active-low.
- `pix_valid`, in, 1: qualifies pixel inputs in this cycle.
- `video_off`, in, 1: blanking; forces black.
- `frame_start`, in, 1: one-cycle pulse per frame.
- `layer_on`, in, N_LAYERS: per-layer coverage of the current pixel.
- `layer_rgb`, in, 12*N_LAYERS: layer i colour at bits [12i+11:12i], 4/4/4 R/G/B.
- `layer_mask`, in, N_LAYERS: per-layer enable, latched at `frame_start`.
- `bg_rgb`, in, 12: background colour.
- `overlay_sel`, in, 1: request for full-screen overlay mode.
- `overlay_rgb`, in, 12: overlay colour.
- `rgb_out`, out, 12: composited, fade-scaled pixel.
- `rgb_valid`, out, 1: `rgb_out` updated this cycle.
- `win_idx`, out, IDX_W: winning source. Values 0..N_LAYERS-1 are layers, N_LAYERS is background/blank, N_LAYERS+1 is overlay.
- `fade_busy`, out, 1: the fade FSM is not in IDLE.

## Operation

Shadow registers:
- `mask_sh` loads `layer_mask` on every `frame_start` cycle, independent of `pix_valid`.
- `ovl_sh` loads only as the fade rules below allow.

Stage 1 (loads only when `pix_valid`=1):
- `video_off`: output 0x000, index N_LAYERS.
- Else if `ovl_sh`: output `overlay_rgb`, index N_LAYERS+1.
- Else: output the lowest i with `layer_on[i]` & `mask_sh[i]` & (`layer_rgb_i` != `KEY_COLOR`), index i.
- If no layer qualifies: output `bg_rgb`, index N_LAYERS.

Stage 2 (loads when the stage-1 valid bit is set):
- Each channel is computed as c_out = (c × level) >> 4, using a 9-bit product.
- `level` is 5 bits, range 0..16. At level 16 the pixel passes through unchanged.
- `level` is sampled in the same cycle the stage-2 register loads.

Fade FSM, with states IDLE, FADE_OUT, FADE_IN. A frame counter counts `frame_start` pulses modulo FADE_FRAMES.
- IDLE, on `frame_start` with `overlay_sel` != `ovl_sh`:
  - FADE_EN=0: latch `ovl_sh` immediately and stay in IDLE.
  - Otherwise: clear the frame counter and go to FADE_OUT.
- FADE_OUT: decrement `level` on each counter wrap. On the `frame_start` where `level` is 0, latch `ovl_sh` from the current `overlay_sel` and go to FADE_IN.
- FADE_IN: increment `level` on each counter wrap. On reaching 16, go to IDLE.
- If `overlay_sel` toggles during a fade, the fade still completes. The value latched is whatever `overlay_sel` holds at the latch instant, even if equal to the old value.
- A mask latch and an FSM step in the same `frame_start` cycle both take effect.

Reset (asynchronous, `rstn`=0):
- `rgb_out` = 0, `rgb_valid` = 0, `win_idx` = N_LAYERS, `fade_busy` = 0.
- `level` = 16, `mask_sh` = 0, `ovl_sh` = 0, state IDLE, frame counter 0.
- Pipeline valid bits are cleared.
- Reset asserted mid-fade or mid-pixel discards all in-flight state.

## Timing

- Latency is exactly 2 clk from a `pix_valid` cycle to `rgb_valid`=1 with the corresponding `rgb_out`/`win_idx`.
- `rgb_valid` is a single-cycle pulse per accepted pixel. Back-to-back `pix_valid` gives back-to-back outputs, sustaining 1 pixel/clk.
- `rgb_out` and `win_idx` hold their last values between valid pixels.
- `mask_sh` and `ovl_sh` affect stage 1 starting the cycle after the `frame_start` that loads them.
- `level` changes in the cycle after `frame_start`. Pixels already in stage 1 use the new `level` at stage 2.
- `fade_busy` rises the cycle after the triggering `frame_start` and falls the cycle after `level` returns to 16.
- Full fade length is 32×FADE_FRAMES + 1 `frame_start` pulses.

## Test plan

- Reset: assert `rstn`=0 mid-fade at `level`=5 → outputs go to their reset values immediately, without waiting for a clock edge; `level` = 16 after release.
- Priority: N=4, `mask_sh`=4'b1111, `layer_on`=4'b0110, rgb1=0x0F0, rgb2=0xF00, then one `pix_valid` → 2 clk later `rgb_out`=0x0F0, `win_idx`=1, `rgb_valid` pulses once.
- Colour key:
  - rgb1=0xF0F → `rgb_out`=0xF00, `win_idx`=2.
  - All covering layers keyed → `bg_rgb`, `win_idx`=4.
- Mask timing: clear mask bit 1 mid-frame → layer 1 still wins until the pixel after the next `frame_start`; `video_off`=1 → 0x000, `win_idx`=4.
- Fade: FADE_FRAMES=1, `overlay_sel` 0→1 at a `frame_start`:
  - `fade_busy`=1; `level` steps 15..0 over the next 16 frames.
  - At `level`=8, pixel 0xFFF → 0x777.
  - Overlay latches at `level` 0, then `level` ramps back to 16 and `fade_busy` drops.
  - `win_idx`=5 thereafter.
- Gaps and FADE_EN=0: `pix_valid` every 4th clk → `rgb_out` holds between valid pixels; FADE_EN=0 → overlay switches at the next `frame_start`, `fade_busy` stays 0.
